// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and per-stage tracking state for the pipeline hazard controller.
package pipe_pkg;

   localparam int DEF_NSTAGE     = 4;
   localparam int DEF_LOAD_STAGE = 3;
   // Stage state stores destinations at this fixed width so one typedef serves every REGW up to it.
   localparam int MAX_REGW       = 8;

   localparam logic [MAX_REGW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                v;
      logic [MAX_REGW-1:0] dst;
      logic                we;
      logic                late;
   } stage_state_t;

endpackage

// File: rtl/pipe_fwd_lookup.sv
// pipe_fwd_lookup: priority scan of the downstream stages for one source operand,
// returning the forwarding stage or a hazard when the producer's result is not yet available.
module pipe_fwd_lookup
   import pipe_pkg::*;
#(
   parameter int NSTAGE     = DEF_NSTAGE,
   parameter int REGW       = 5,
   parameter int LOAD_STAGE = DEF_LOAD_STAGE,
   parameter int SELW       = $clog2(NSTAGE)
) (
   input  logic [REGW-1:0]                 i_src,
   input  logic                            i_used,
   input  logic [NSTAGE-2:0]               i_v,
   input  logic [NSTAGE-2:0]               i_we,
   input  logic [NSTAGE-2:0]               i_late,
   input  logic [(NSTAGE-1)*MAX_REGW-1:0]  i_dst,
   output logic [SELW-1:0]                 o_sel,
   output logic                            o_haz
);

   always_comb begin
      o_sel = '0;
      o_haz = 1'b0;
      // Oldest first so the youngest matching producer overwrites and wins.
      if (i_used && MAX_REGW'(i_src) != REG_ZERO)
         for (int s = NSTAGE - 1; s >= 1; s--)
            if (i_v[s-1] && i_we[s-1] && i_dst[(s-1)*MAX_REGW +: MAX_REGW] == MAX_REGW'(i_src)) begin
               o_haz = i_late[s-1] && (s < LOAD_STAGE);
               o_sel = o_haz ? '0 : SELW'(s);
            end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: tracks every stage downstream of decode and produces load enables,
// the decode stall, flush handling and per-source forwarding selects.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int NSTAGE     = DEF_NSTAGE,
   parameter int REGW       = 5,
   parameter int NSRC       = 2,
   parameter int LOAD_STAGE = DEF_LOAD_STAGE,
   parameter int SELW       = $clog2(NSTAGE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_id_valid,
   input  logic [NSRC*REGW-1:0]   i_id_src,
   input  logic [NSRC-1:0]        i_id_src_used,
   input  logic [REGW-1:0]        i_id_dst,
   input  logic                   i_id_dst_we,
   input  logic                   i_id_late,
   input  logic [NSTAGE-2:0]      i_stage_busy,
   input  logic                   i_flush,
   input  logic [SELW-1:0]        i_flush_upto,
   output logic                   o_id_accept,
   output logic                   o_stall,
   output logic [NSTAGE-2:0]      o_stage_load,
   output logic [NSTAGE-2:0]      o_stage_valid,
   output logic [NSRC*SELW-1:0]   o_fwd_sel
);

   localparam int NS = NSTAGE - 1;

   stage_state_t               r_st [1:NS];
   stage_state_t               w_in [1:NS];
   logic [NS:0]                w_rg;
   logic [NSTAGE:1]            w_allowin;
   logic [NS-1:0]              w_v, w_we, w_late;
   logic [NS*MAX_REGW-1:0]     w_dst;
   logic [NSRC-1:0]            w_haz;
   logic                       w_stall;
   logic                       w_active;

   assign w_allowin[NSTAGE] = 1'b1;
   assign w_stall           = i_id_valid & (|w_haz);
   assign w_rg[0]           = i_id_valid & ~w_stall;
   // An empty pipeline with nothing arriving has nothing to move, so no register loads.
   assign w_active          = i_id_valid | (|w_v);

   for (genvar s = 1; s <= NS; s++) begin : g_stg
      assign w_v[s-1]                        = r_st[s].v;
      assign w_we[s-1]                       = r_st[s].we;
      assign w_late[s-1]                     = r_st[s].late;
      assign w_dst[(s-1)*MAX_REGW +: MAX_REGW] = r_st[s].dst;
      assign w_rg[s]                         = ~i_stage_busy[s-1];
      assign w_allowin[s]                    = ~r_st[s].v | (w_rg[s] & w_allowin[s+1]);
   end

   assign o_stage_load  = w_allowin[NS:1] & {NS{w_active}};
   assign o_stage_valid = w_v;
   assign o_stall       = w_stall;
   assign o_id_accept   = w_rg[0] & w_allowin[1] & ~i_flush;

   always_comb begin
      w_in[1] = '{v: w_rg[0], dst: MAX_REGW'(i_id_dst), we: i_id_dst_we, late: i_id_late};
      // The stage just above the flush boundary takes a bubble instead of a killed instruction.
      for (int s = 2; s <= NS; s++) begin
         w_in[s]   = r_st[s-1];
         w_in[s].v = r_st[s-1].v & w_rg[s-1] & ~(i_flush && i_flush_upto == SELW'(s - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         for (int s = 1; s <= NS; s++) r_st[s].v <= 1'b0;
      else
         for (int s = 1; s <= NS; s++)
            if (i_flush && i_flush_upto >= SELW'(s)) r_st[s].v <= 1'b0;
            else if (o_stage_load[s-1]) r_st[s] <= w_in[s];
   end

   for (genvar j = 0; j < NSRC; j++) begin : g_src
      pipe_fwd_lookup #(
         .NSTAGE     (NSTAGE),
         .REGW       (REGW),
         .LOAD_STAGE (LOAD_STAGE),
         .SELW       (SELW)
      ) u_lookup (
         .i_src  (i_id_src[j*REGW +: REGW]),
         .i_used (i_id_src_used[j]),
         .i_v    (w_v),
         .i_we   (w_we),
         .i_late (w_late),
         .i_dst  (w_dst),
         .o_sel  (o_fwd_sel[j*SELW +: SELW]),
         .o_haz  (w_haz[j])
      );
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed cycles push hand-computed expectations into a queue;
// a monitor on the falling edge pops and compares every output of the controller.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, id_dst_we = 1'b0, id_late = 1'b0, flush = 1'b0;
   logic [9:0] id_src = '0;
   logic [1:0] id_src_used = '0, flush_upto = '0;
   logic [4:0] id_dst = '0;
   logic [2:0] stage_busy = '0;
   logic       id_accept, stall;
   logic [2:0] stage_load, stage_valid;
   logic [3:0] fwd_sel;

   typedef struct {
      string      nm;
      logic       acc;
      logic       st;
      logic [2:0] ld;
      logic [2:0] vl;
      logic [3:0] fw;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_id_valid    (id_valid),
      .i_id_src      (id_src),
      .i_id_src_used (id_src_used),
      .i_id_dst      (id_dst),
      .i_id_dst_we   (id_dst_we),
      .i_id_late     (id_late),
      .i_stage_busy  (stage_busy),
      .i_flush       (flush),
      .i_flush_upto  (flush_upto),
      .o_id_accept   (id_accept),
      .o_stall       (stall),
      .o_stage_load  (stage_load),
      .o_stage_valid (stage_valid),
      .o_fwd_sel     (fwd_sel)
   );

   task automatic drv(input logic r, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] u, input logic [4:0] d, input logic we, input logic lt,
                      input logic [2:0] b, input logic fl, input logic [1:0] up);
      @(posedge clk);
      #1;
      rst_n       = r;
      id_valid    = v;
      id_src      = {s1, s0};
      id_src_used = u;
      id_dst      = d;
      id_dst_we   = we;
      id_late     = lt;
      stage_busy  = b;
      flush       = fl;
      flush_upto  = up;
   endtask

   task automatic expect_out(input string nm, input logic a, input logic s, input logic [2:0] ld,
                             input logic [2:0] vl, input logic [3:0] fw);
      exp_t e;
      e.nm = nm; e.acc = a; e.st = s; e.ld = ld; e.vl = vl; e.fw = fw;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input string f, input logic [3:0] act, input logic [3:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s: got %b, expected %b", nm, f, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, "id_accept",   {3'b000, id_accept}, {3'b000, e.acc});
            chk(e.nm, "stall",       {3'b000, stall},     {3'b000, e.st});
            chk(e.nm, "stage_load",  {1'b0, stage_load},  {1'b0, e.ld});
            chk(e.nm, "stage_valid", {1'b0, stage_valid}, {1'b0, e.vl});
            chk(e.nm, "fwd_sel",     fwd_sel,             e.fw);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //      r  v  s0  s1  u  d   we lt busy    fl up
      drv(0, 1'b0, 5'd0,  5'd0, 2'b00, 5'd0,  1'b0, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("reset_idle",  1'b0, 1'b0, 3'b000, 3'b000, 4'b0000);
      drv(0, 1'b1, 5'd0,  5'd0, 2'b00, 5'd3,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("reset_hold",  1'b1, 1'b0, 3'b111, 3'b000, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd3,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("first_acc",   1'b1, 1'b0, 3'b111, 3'b000, 4'b0000);
      drv(1, 1'b1, 5'd3,  5'd0, 2'b01, 5'd6,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("alu_fwd",     1'b1, 1'b0, 3'b111, 3'b001, 4'b0001);
      drv(1, 1'b1, 5'd6,  5'd3, 2'b11, 5'd4,  1'b1, 1'b1, 3'b000, 1'b0, 2'd0);
      expect_out("two_src_fwd", 1'b1, 1'b0, 3'b111, 3'b011, 4'b1001);
      drv(1, 1'b1, 5'd4,  5'd0, 2'b01, 5'd0,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("ld_use_s1",   1'b0, 1'b1, 3'b111, 3'b111, 4'b0000);
      drv(1, 1'b1, 5'd4,  5'd0, 2'b01, 5'd0,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("ld_use_s2",   1'b0, 1'b1, 3'b111, 3'b110, 4'b0000);
      drv(1, 1'b1, 5'd4,  5'd0, 2'b01, 5'd0,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("ld_use_s3",   1'b1, 1'b0, 3'b111, 3'b100, 4'b0011);
      drv(1, 1'b1, 5'd0,  5'd7, 2'b01, 5'd5,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("reg0_unused", 1'b1, 1'b0, 3'b111, 3'b001, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd5,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("fill5",       1'b1, 1'b0, 3'b111, 3'b011, 4'b0000);
      drv(1, 1'b1, 5'd5,  5'd0, 2'b11, 5'd2,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("youngest",    1'b1, 1'b0, 3'b111, 3'b111, 4'b0001);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd9,  1'b1, 1'b0, 3'b001, 1'b0, 2'd0);
      expect_out("busy1",       1'b0, 1'b0, 3'b110, 3'b111, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd9,  1'b1, 1'b0, 3'b001, 1'b0, 2'd0);
      expect_out("busy2",       1'b0, 1'b0, 3'b110, 3'b101, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd9,  1'b1, 1'b0, 3'b001, 1'b0, 2'd0);
      expect_out("busy3",       1'b0, 1'b0, 3'b110, 3'b001, 4'b0000);
      drv(1, 1'b1, 5'd2,  5'd0, 2'b01, 5'd9,  1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("release",     1'b1, 1'b0, 3'b111, 3'b001, 4'b0001);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd10, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("refill",      1'b1, 1'b0, 3'b111, 3'b011, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd11, 1'b1, 1'b0, 3'b000, 1'b1, 2'd1);
      expect_out("flush1",      1'b0, 1'b0, 3'b111, 3'b111, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("post_flush1", 1'b1, 1'b0, 3'b111, 3'b100, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd13, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("refill2",     1'b1, 1'b0, 3'b111, 3'b001, 4'b0000);
      drv(1, 1'b1, 5'd12, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2);
      expect_out("flush2",      1'b0, 1'b0, 3'b111, 3'b011, 4'b0010);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd15, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("post_flush2", 1'b1, 1'b0, 3'b111, 3'b000, 4'b0000);
      drv(1, 1'b1, 5'd0,  5'd0, 2'b00, 5'd16, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("refill3",     1'b1, 1'b0, 3'b111, 3'b001, 4'b0000);
      drv(0, 1'b1, 5'd16, 5'd0, 2'b01, 5'd17, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("mid_reset",   1'b1, 1'b0, 3'b111, 3'b011, 4'b0001);
      drv(1, 1'b0, 5'd16, 5'd0, 2'b01, 5'd0,  1'b0, 1'b0, 3'b000, 1'b0, 2'd0);
      expect_out("post_reset",  1'b0, 1'b0, 3'b000, 3'b000, 4'b0000);
      repeat (3) @(posedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control unit for the in-order MIPS core. It replaces the hard-wired go/allowin equations and the fixed-depth RAW stall check with one block. The block tracks valid, destination register and result-availability for every stage downstream of decode. From that state it produces per-stage load enables, a decode stall, flush handling and per-source forwarding selects. It sits beside the datapath: decode feeds it, and stage registers consume its enables.

Parameters:
NSTAGE, 4, total stages including decode (stage 0) and write-back (stage NSTAGE-1)
REGW, 5, register-number width
NSRC, 2, source operands checked per decoded instruction
LOAD_STAGE, 3, first stage whose output carries late (load) results
SELW, $clog2(NSTAGE), forwarding-select width

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
id_valid  in  1  decode holds a valid instruction
id_src  in  NSRC*REGW  source register numbers; source j at bits [j*REGW +: REGW]
id_src_used  in  NSRC  source j is actually read
id_dst  in  REGW  destination register
id_dst_we  in  1  instruction writes id_dst
id_late  in  1  result available only from LOAD_STAGE (loads)
stage_busy  in  NSTAGE-1  bit s-1: stage s cannot finish this cycle (multicycle op / memory wait)
flush  in  1  kill stages 1..flush_upto
flush_upto  in  SELW  youngest-to-oldest kill bound, range 1..NSTAGE-2
id_accept  out  1  decode instruction enters stage 1 at this edge
stall  out  1  RAW hazard blocks decode
stage_load  out  NSTAGE-1  bit s-1: datapath register of stage s loads at this edge
stage_valid  out  NSTAGE-1  bit s-1: stage s holds a valid instruction
fwd_sel  out  NSRC*SELW  per source: 0 = register file, k = forward from stage k output

Behaviour:
- State per stage s = 1..NSTAGE-1: v[s], dst[s], we[s], late[s].
- Reset, synchronous active-low:
  - All v clear at the reset edge; dst, we and late are don't-care.
  - With v clear and id_valid low, every output is 0.
  - Reset asserted mid-operation discards all in-flight instructions. The first post-reset edge with id_valid=1 can load stage 1.
- Handshake (combinational):
  - ready_go[s] = !stage_busy[s]
  - allowin[NSTAGE] = 1
  - allowin[s] = !v[s] | (ready_go[s] & allowin[s+1])
  - ready_go[0] = id_valid & !stall
- id_accept = ready_go[0] & allowin[1] & !flush.
- stage_load[s] = allowin[s]. On load:
  - v[s] <= v[s-1] & ready_go[s-1], with v[0] := id_valid.
  - Stage 1 captures id_dst, id_dst_we, id_late.
  - When not loading, a stage holds its contents; a leaving instruction with no replacement becomes a bubble (v=0).
- Hazard / forward, per source j with id_src_used[j]=1 and id_src[j]!=0:
  - Scan s = 1..NSTAGE-1 youngest first; the first s with v[s] & we[s] & dst[s]==id_src[j] is the match.
  - ready(s) = !late[s] | (s >= LOAD_STAGE).
  - Match and ready: fwd_sel[j] = s.
  - Match and not ready: stall = 1, fwd_sel[j] = 0.
  - No match: fwd_sel[j] = 0.
  - Unused sources and register 0 never stall; their fwd_sel is 0.
- stall is the OR over all sources, gated by id_valid.
- Latency: hazard and forward outputs are combinational in the same cycle; state updates at the next edge.
- Flush:
  - At the edge, v[1..flush_upto] <= 0.
  - Stage flush_upto+1, if loading, receives a bubble.
  - Stages above flush_upto+1 advance normally.
  - Flush overrides simultaneous load or hold in the affected stages; id_accept = 0 that cycle.
- Back-pressure:
  - A busy stage holds; all younger stages hold while full.
  - The next older stage receives bubbles while the busy stage holds.
  - Write-back (stage NSTAGE-1) drains whenever not busy.
- Simultaneous match in several stages: the youngest wins, because it holds the newest value.

Decomposition:
- Package pipe_pkg: REG_ZERO constant, the default NSTAGE/LOAD_STAGE values, and a packed stage_state_t typedef (v, dst, we, late).
- Sub-module pipe_fwd_lookup: per-source priority scan returning fwd_sel and a per-source hazard bit, instantiated NSRC times via generate.

Test Plan:
1. Back-to-back ALU, default params: cycle n accepts dst=3 we=1; cycle n+1 id_src[0]=3 -> fwd_sel[0]=1, stall=0, id_accept=1.
2. Load-use: load with dst=4, id_late=1, then consumer of $4:
   - Consumer cycle with load in stage 1 -> stall=1, stage_load[0]=1, stage 1 receives a bubble.
   - When the load is in stage 2 -> stall=1.
   - When the load is in stage 3 -> stall=0, fwd_sel=3.
3. Register 0 and unused source: id_src={0,7}, id_src_used=2'b01, stage 1 dst=0 we=1 -> stall=0, fwd_sel=0 for both sources.
4. Youngest-wins: stage 1 dst=5 and stage 2 dst=5, both we=1 -> fwd_sel[0]=1.
5. Back-pressure: stage_busy=3'b001 for 3 cycles, all stages full:
   - Stage 1 holds, id_accept=0, stage_load = 3'b110 each cycle.
   - Stage 2 receives a bubble at the first edge; stage 3 drains at the second edge.
   - Stages 2 and 3 are both invalid by the third cycle.
6. Flush plus reset:
   - flush=1, flush_upto=1 with id_valid=1 -> next cycle stage_valid[0]=0 and stage 2 contains a bubble; id_accept=0 during the flush cycle.
   - rst_n=0 for one edge mid-stream -> stage_valid=0, stall=0.
